// File: rtl/pwm_audio_pkg.sv
// ----------------------------------------------------------------------------
// pwm_audio_pkg
// Shared types and constants for the PWM audio demodulator.
//   tone_state_t : tone level tracker state (LOW / HIGH)
//   mid_level()  : half-scale duty threshold for a given frame width
//   *_DEF        : default parameter values used by pwm_audio_demod
// ----------------------------------------------------------------------------
package pwm_audio_pkg;

  localparam int PERIOD_W_DEF       = 8;
  localparam int TONE_W_DEF         = 12;
  localparam int SILENCE_FRAMES_DEF = 16;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } tone_state_t;

  // Half of the frame length: a sample at or above this is "tone high".
  function automatic int mid_level(input int period_w);
    return 1 << (period_w - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, output forced to 0
//   d_i : asynchronous input
//   q_o : synchronized output (two clock cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_audio_demod.sv
// ----------------------------------------------------------------------------
// pwm_audio_demod
// Recovers one duty-cycle sample per PWM frame from a 1-bit PWM stream,
// measures the audio tone period in frames and flags silence.
// Ports:
//   clk            : system clock
//   rst            : asynchronous active-high reset
//   pwm_in         : PWM stream, asynchronous to clk
//   sample_o       : high-cycle count of the last completed frame
//   sample_valid_o : one-cycle pulse when sample_o updates
//   tone_period_o  : frames between the last two rising tone crossings
//   tone_valid_o   : one-cycle pulse when tone_period_o updates
//   active_o       : 1 while audio edges are present, 0 when silent
// ----------------------------------------------------------------------------
module pwm_audio_demod
  import pwm_audio_pkg::*;
#(
  parameter int PERIOD_W       = PERIOD_W_DEF,
  parameter int TONE_W         = TONE_W_DEF,
  parameter int SILENCE_FRAMES = SILENCE_FRAMES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [PERIOD_W:0] sample_o,
  output logic              sample_valid_o,
  output logic [TONE_W-1:0] tone_period_o,
  output logic              tone_valid_o,
  output logic              active_o
);

  localparam int SW = PERIOD_W + 1;
  localparam int QW = $clog2(SILENCE_FRAMES + 1);

  localparam logic [SW-1:0]       MID       = SW'(mid_level(PERIOD_W));
  localparam logic [PERIOD_W-1:0] FRAME_MAX = '1;
  localparam logic [TONE_W-1:0]   TONE_MAX  = '1;
  localparam logic [QW-1:0]       QUIET_LIM = QW'(SILENCE_FRAMES);

  function automatic logic [TONE_W-1:0] tone_sat_inc(input logic [TONE_W-1:0] x);
    return (x == TONE_MAX) ? x : x + TONE_W'(1);
  endfunction

  function automatic logic [QW-1:0] quiet_sat_inc(input logic [QW-1:0] x);
    return (x == QUIET_LIM) ? x : x + QW'(1);
  endfunction

  logic                pwm_s;
  logic                pwm_s_d_q;
  logic                rise;
  logic                frame_end;
  logic [SW-1:0]       s_new;

  logic [PERIOD_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SW-1:0]       hi_cnt_q, hi_cnt_d;
  logic [SW-1:0]       sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  tone_state_t         tone_state_q, tone_state_d;
  logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic                armed_q, armed_d;
  logic [TONE_W-1:0]   tone_period_q, tone_period_d;
  logic                tone_valid_q, tone_valid_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic                seen_q, seen_d;
  logic                active_q, active_d;

  // ---- input synchronization ----
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pwm_in),
    .q_o (pwm_s)
  );

  // ---- framing, silence and tone tracking ----
  always_comb begin
    rise      = pwm_s & ~pwm_s_d_q;
    frame_end = (frame_cnt_q == FRAME_MAX);
    // The current cycle's level belongs to the frame that is ending.
    s_new     = hi_cnt_q + SW'(pwm_s);

    frame_cnt_d    = frame_cnt_q + PERIOD_W'(1);
    hi_cnt_d       = s_new;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    tone_state_d   = tone_state_q;
    tone_cnt_d     = tone_cnt_q;
    armed_d        = armed_q;
    tone_period_d  = tone_period_q;
    tone_valid_d   = 1'b0;
    quiet_d        = quiet_q;
    seen_d         = seen_q | rise;
    active_d       = active_q;

    if (rise) begin
      quiet_d  = '0;
      active_d = 1'b1;
    end

    if (frame_end) begin
      hi_cnt_d       = '0;
      sample_d       = s_new;
      sample_valid_d = 1'b1;
      seen_d         = 1'b0;

      // An edge on the frame's last cycle still counts for this frame.
      if (!(seen_q || rise)) begin
        quiet_d = quiet_sat_inc(quiet_q);
        if (quiet_d == QUIET_LIM) begin
          active_d = 1'b0;
        end
      end

      // Silence disarms the tracker so the next tone only re-arms it.
      if (!active_d) begin
        tone_state_d = LOW;
        armed_d      = 1'b0;
        tone_cnt_d   = '0;
      end else if (tone_state_q == LOW && s_new >= MID) begin
        tone_state_d = HIGH;
        if (armed_q) begin
          tone_period_d = tone_sat_inc(tone_cnt_q);
          tone_valid_d  = 1'b1;
        end
        armed_d    = 1'b1;
        tone_cnt_d = '0;
      end else begin
        if (tone_state_q == HIGH && s_new < MID) begin
          tone_state_d = LOW;
        end
        tone_cnt_d = tone_sat_inc(tone_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_s_d_q      <= 1'b0;
      frame_cnt_q    <= '0;
      hi_cnt_q       <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      tone_state_q   <= LOW;
      tone_cnt_q     <= '0;
      armed_q        <= 1'b0;
      tone_period_q  <= '0;
      tone_valid_q   <= 1'b0;
      quiet_q        <= '0;
      seen_q         <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      pwm_s_d_q      <= pwm_s;
      frame_cnt_q    <= frame_cnt_d;
      hi_cnt_q       <= hi_cnt_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      tone_state_q   <= tone_state_d;
      tone_cnt_q     <= tone_cnt_d;
      armed_q        <= armed_d;
      tone_period_q  <= tone_period_d;
      tone_valid_q   <= tone_valid_d;
      quiet_q        <= quiet_d;
      seen_q         <= seen_d;
      active_q       <= active_d;
    end
  end

  // ---- outputs ----
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign tone_period_o  = tone_period_q;
  assign tone_valid_o   = tone_valid_q;
  assign active_o       = active_q;

endmodule

// File: tb/tb_pwm_audio_demod.sv
// ----------------------------------------------------------------------------
// tb_pwm_audio_demod
// Self-checking bench: directed phases plus randomized PWM segments, every
// cycle compared against a frame-level reference model of the demodulator.
// ----------------------------------------------------------------------------
module tb_pwm_audio_demod;

  logic        clk;
  logic        rst;
  logic        pwm_in;
  logic [8:0]  sample_o;
  logic        sample_valid_o;
  logic [11:0] tone_period_o;
  logic        tone_valid_o;
  logic        active_o;

  pwm_audio_demod #(
    .PERIOD_W       (8),
    .TONE_W         (12),
    .SILENCE_FRAMES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pwm_in         (pwm_in),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .tone_period_o  (tone_period_o),
    .tone_valid_o   (tone_valid_o),
    .active_o       (active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---- reference model: frame-level view of the stream ----
  localparam int FRAME    = 256;
  localparam int MIDV     = 128;
  localparam int TONE_SAT = 4095;
  localparam int QUIET_N  = 16;

  bit          dly[$];       // two-cycle synchronizer delay line
  bit          s_prev;
  int          pos, fsum, quiet, frame_idx, last_cross;
  bit          edge_in_frame, m_active, lvl_hi, armed;
  logic [8:0]  e_sample;
  logic [11:0] e_tp;
  bit          e_sv, e_tv;

  // Observed-event bookkeeping for directed checks.
  int cyc, n_sv, n_tv, first_sample, first_sv_cyc, last_sample;
  int first_tv_cyc, last_tp, first_active_cyc, first_rise_cyc, fall_cyc;
  bit prev_in, prev_active;

  function void bench_reset();
    dly.delete();
    dly.push_back(1'b0);
    dly.push_back(1'b0);
    s_prev = 0; pos = 0; fsum = 0; quiet = 0; frame_idx = 0; last_cross = 0;
    edge_in_frame = 0; m_active = 0; lvl_hi = 0; armed = 0;
    e_sample = '0; e_tp = '0; e_sv = 0; e_tv = 0;
    cyc = 0; n_sv = 0; n_tv = 0; first_sample = -1; first_sv_cyc = -1;
    last_sample = -1; first_tv_cyc = -1; last_tp = -1;
    first_active_cyc = -1; first_rise_cyc = -1; fall_cyc = -1;
    prev_in = 0; prev_active = 0;
  endfunction

  function void model_step(input bit in);
    bit s, rise;
    int gap;
    s = dly.pop_front();
    dly.push_back(in);
    rise   = s && !s_prev;
    s_prev = s;
    e_sv = 0;
    e_tv = 0;
    fsum += s;
    if (rise) begin
      edge_in_frame = 1;
      m_active      = 1;
      quiet         = 0;
    end
    if (pos == FRAME - 1) begin
      e_sample = 9'(fsum);
      e_sv     = 1;
      if (!edge_in_frame) begin
        quiet++;
        if (quiet >= QUIET_N) m_active = 0;
      end
      edge_in_frame = 0;
      if (!m_active) begin
        lvl_hi = 0;
        armed  = 0;
      end else if (!lvl_hi && fsum >= MIDV) begin
        if (armed) begin
          gap  = frame_idx - last_cross;
          e_tp = 12'((gap > TONE_SAT) ? TONE_SAT : gap);
          e_tv = 1;
        end
        armed      = 1;
        last_cross = frame_idx;
        lvl_hi     = 1;
      end else if (lvl_hi && fsum < MIDV) begin
        lvl_hi = 0;
      end
      fsum = 0;
      frame_idx++;
    end
    pos = (pos + 1) % FRAME;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bench_reset();
    end else begin
      model_step(pwm_in);
      if (pwm_in && !prev_in && first_rise_cyc < 0) first_rise_cyc = cyc;
      prev_in = pwm_in;
      #1;
      chk("flags", 32'({sample_valid_o, tone_valid_o, active_o}), 32'({e_sv, e_tv, m_active}));
      chk("data", 32'({sample_o, tone_period_o}), 32'({e_sample, e_tp}));
      if (sample_valid_o) begin
        if (n_sv == 0) begin
          first_sample = int'(sample_o);
          first_sv_cyc = cyc;
        end
        last_sample = int'(sample_o);
        n_sv++;
      end
      if (tone_valid_o) begin
        if (n_tv == 0) first_tv_cyc = cyc;
        last_tp = int'(tone_period_o);
        n_tv++;
      end
      if (active_o && first_active_cyc < 0) first_active_cyc = cyc;
      if (!active_o && prev_active) fall_cyc = cyc;
      prev_active = active_o;
      cyc++;
    end
  end

  // ---- stimulus ----
  int t;

  task drive_bit(input bit v);
    pwm_in = v;
    t++;
    @(negedge clk);
  endtask

  task do_reset();
    @(negedge clk);
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t   = 0;
  endtask

  function bit tone_bit(input int tt);
    int d;
    d = (((tt / FRAME) / 8) % 2 == 0) ? 200 : 50;
    return (tt % FRAME) < d;
  endfunction

  task automatic run_random(input int frames);
    int f, kind, len, duty, ph, hp;
    f = 0;
    while (f < frames) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 20);
      if (len > frames - f) len = frames - f;
      hp = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        duty = $urandom_range(0, 256);
        ph   = $urandom_range(0, 255);
        for (int c = 0; c < FRAME; c++) begin
          case (kind)
            0:       drive_bit(((c + ph) % FRAME) < duty);
            1:       drive_bit(1'b0);
            2:       drive_bit(1'b1);
            default: drive_bit(c < ((((f + i) / hp) % 2 == 0) ? 200 : 50));
          endcase
        end
      end
      f += len;
    end
  endtask

  int ph;

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    t      = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({sample_o, sample_valid_o, tone_period_o, tone_valid_o, active_o}), 32'd0);
    rst = 1'b0;

    // Constant low: zero samples, never active.
    repeat (4 * FRAME) drive_bit(1'b0);
    chk("zero_nsv", n_sv, 4);
    chk("zero_sample", last_sample, 0);
    chk("zero_never_active", first_active_cyc, -1);

    // Constant high: sync latency eats two cycles, then silence after 16 frames.
    do_reset();
    repeat (20 * FRAME) drive_bit(1'b1);
    chk("held1_first", first_sample, 254);
    chk("held1_first_cyc", first_sv_cyc, FRAME - 1);
    chk("held1_last", last_sample, 256);
    chk("held1_active_on", first_active_cyc, 2);
    chk("held1_fall_cyc", fall_cyc, 17 * FRAME - 1);
    chk("held1_active_end", active_o, 0);

    // Duty 64 at a random phase.
    do_reset();
    ph = $urandom_range(0, 255);
    repeat (6 * FRAME) drive_bit(((t + ph) % FRAME) < 64);
    chk("d64_last", last_sample, 64);
    chk("d64_nsv", n_sv, 6);
    chk("d64_active_lat", first_active_cyc - first_rise_cyc, 2);
    chk("d64_active", active_o, 1);

    // Tone: 8 frames high duty, 8 frames low duty.
    do_reset();
    repeat (64 * FRAME) drive_bit(tone_bit(t));
    chk("tone_count", n_tv, 3);
    chk("tone_first_cyc", first_tv_cyc, 16 * FRAME + FRAME - 1);
    chk("tone_period", last_tp, 16);

    // Silence, then resume the tone.
    do_reset();
    repeat (10 * FRAME) drive_bit((t % FRAME) < 64);
    repeat (16 * FRAME) drive_bit(1'b0);
    chk("sil_fall_cyc", fall_cyc, 26 * FRAME - 1);
    chk("sil_active", active_o, 0);
    repeat (40 * FRAME) drive_bit(tone_bit(t - 26 * FRAME));
    chk("sil_tone_count", n_tv, 2);
    chk("sil_first_tone_cyc", first_tv_cyc, 42 * FRAME + FRAME - 1);
    chk("sil_tone_period", last_tp, 16);

    // Randomized segments.
    do_reset();
    run_random(60);
    chk("rand_nsv", n_sv, 60);

    // Reset in the middle of a frame.
    do_reset();
    ph = $urandom_range(0, 255);
    repeat (2 * FRAME + 100) drive_bit(((t + ph) % FRAME) < 64);
    chk("mid_pre_active", active_o, 1);
    chk("mid_pre_sample", sample_o, 64);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_async_zero", 32'({sample_o, sample_valid_o, tone_period_o, tone_valid_o, active_o}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t   = 0;
    repeat (FRAME - 1) drive_bit(((t + ph) % FRAME) < 64);
    chk("mid_no_early_sv", n_sv, 0);
    drive_bit(((t + ph) % FRAME) < 64);
    chk("mid_first_sv_cyc", first_sv_cyc, FRAME - 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
